// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for the sequential ALU
interface alu_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   func;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] RES;
    logic         zf;
    logic         nf;
    logic         cf;
    logic         vf;
    logic         busy;

    // Producer side: issues operands and accepts results
    modport master (
        output in_valid, A, B, func, out_ready,
        input  in_ready, out_valid, RES, zf, nf, cf, vf, busy
    );

    // ALU side
    modport slave (
        input  in_valid, A, B, func, out_ready,
        output in_ready, out_valid, RES, zf, nf, cf, vf, busy
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered multi-cycle 16-function ALU with variable shifts, popcount and flags
module alu_seq #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input logic    clk,
    input logic    rstn,
    alu_seq_if.slave bus
);
    // Counter wide enough to hold N itself (popcount iterations and result)
    localparam int CW = SW + 1;

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_AND = 4'd2;
    localparam logic [3:0] F_OR  = 4'd3;
    localparam logic [3:0] F_XOR = 4'd4;
    localparam logic [3:0] F_NOR = 4'd5;
    localparam logic [3:0] F_NOT = 4'd6;
    localparam logic [3:0] F_SLL = 4'd7;
    localparam logic [3:0] F_SRL = 4'd8;
    localparam logic [3:0] F_SRA = 4'd9;
    localparam logic [3:0] F_INC = 4'd10;
    localparam logic [3:0] F_DEC = 4'd11;
    localparam logic [3:0] F_SLT = 4'd12;
    localparam logic [3:0] F_SGT = 4'd13;
    localparam logic [3:0] F_LUI = 4'd14;
    localparam logic [3:0] F_POP = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    op_q;
    logic [N-1:0]  work_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] pop_q;
    logic [N-1:0]  res_q;
    logic          zf_q;
    logic          nf_q;
    logic          cf_q;
    logic          vf_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;

    logic [N-1:0]  opb;
    logic [N:0]    add_w;
    logic [N:0]    sub_w;
    logic [N-1:0]  alu_res;
    logic          alu_cf;
    logic          alu_vf;

    logic [N-1:0]  work_d;
    logic          shout_d;
    logic [CW-1:0] pop_d;

    logic [N-1:0]  fin_res;
    logic          fin_cf;
    logic          fin_vf;

    logic [SW-1:0] shamt;
    logic          is_shift;

    assign shamt    = bus.B[SW-1:0];
    assign is_shift = (bus.func == F_SLL) || (bus.func == F_SRL) || (bus.func == F_SRA);

    // Single-cycle result from the live operands; only used on the accept edge
    always_comb begin
        opb     = ((bus.func == F_INC) || (bus.func == F_DEC)) ? N'(1) : bus.B;
        add_w   = {1'b0, bus.A} + {1'b0, opb};
        sub_w   = {1'b0, bus.A} - {1'b0, opb};
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_vf  = 1'b0;
        case (bus.func)
            F_ADD, F_INC: begin
                alu_res = add_w[N-1:0];
                alu_cf  = add_w[N];
                alu_vf  = (bus.A[N-1] == opb[N-1]) && (add_w[N-1] != bus.A[N-1]);
            end
            F_SUB, F_DEC: begin
                alu_res = sub_w[N-1:0];
                alu_cf  = ~sub_w[N];
                alu_vf  = (bus.A[N-1] != opb[N-1]) && (sub_w[N-1] != bus.A[N-1]);
            end
            F_AND: alu_res = bus.A & bus.B;
            F_OR:  alu_res = bus.A | bus.B;
            F_XOR: alu_res = bus.A ^ bus.B;
            F_NOR: alu_res = ~(bus.A | bus.B);
            F_NOT: alu_res = ~bus.A;
            // Zero-amount shifts complete immediately with A unchanged
            F_SLL, F_SRL, F_SRA: alu_res = bus.A;
            F_SLT: alu_res[0] = ($signed(bus.A) < $signed(bus.B));
            F_SGT: alu_res[0] = ($signed(bus.A) > $signed(bus.B));
            F_LUI: alu_res = {bus.A[N/2-1:0], {(N/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    // One iteration of the shift / popcount loop
    always_comb begin
        work_d  = work_q;
        shout_d = 1'b0;
        case (op_q)
            F_SLL: begin
                work_d  = {work_q[N-2:0], 1'b0};
                shout_d = work_q[N-1];
            end
            F_SRL: begin
                work_d  = {1'b0, work_q[N-1:1]};
                shout_d = work_q[0];
            end
            F_SRA: begin
                work_d  = {work_q[N-1], work_q[N-1:1]};
                shout_d = work_q[0];
            end
            default: work_d = {1'b0, work_q[N-1:1]};
        endcase
        pop_d = pop_q + CW'(work_q[0]);
    end

    // Value that lands in RES when the state machine enters DONE
    always_comb begin
        fin_res = alu_res;
        fin_cf  = alu_cf;
        fin_vf  = alu_vf;
        if (state_q == EXEC) begin
            fin_res = (op_q == F_POP) ? N'(pop_d) : work_d;
            fin_cf  = (op_q == F_POP) ? 1'b0 : shout_d;
            fin_vf  = 1'b0;
        end
    end

    // Control FSM with registered handshake outputs, result and flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            op_q        <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            pop_q       <= '0;
            res_q       <= '0;
            zf_q        <= 1'b0;
            nf_q        <= 1'b0;
            cf_q        <= 1'b0;
            vf_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.func;
                        in_ready_q <= 1'b0;
                        if ((is_shift && (shamt != '0)) || (bus.func == F_POP)) begin
                            state_q <= EXEC;
                            busy_q  <= 1'b1;
                            work_q  <= bus.A;
                            pop_q   <= '0;
                            cnt_q   <= (bus.func == F_POP) ? CW'(N) : CW'(shamt);
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            res_q       <= fin_res;
                            zf_q        <= (fin_res == '0);
                            nf_q        <= fin_res[N-1];
                            cf_q        <= fin_cf;
                            vf_q        <= fin_vf;
                        end
                    end
                end
                EXEC: begin
                    work_q <= work_d;
                    pop_q  <= pop_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        res_q       <= fin_res;
                        zf_q        <= (fin_res == '0);
                        nf_q        <= fin_res[N-1];
                        cf_q        <= fin_cf;
                        vf_q        <= fin_vf;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.RES       = res_q;
    assign bus.zf        = zf_q;
    assign bus.nf        = nf_q;
    assign bus.cf        = cf_q;
    assign bus.vf        = vf_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int N = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cur_func = 0;

    alu_seq_if #(.N(N)) bus ();

    alu_seq #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cf;
        logic        vf;
        int          lat;
    } exp_t;

    function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] u;
        logic [31:0] bb;
        int          s;
        e.res = '0; e.cf = 1'b0; e.vf = 1'b0; e.lat = 1;
        bb = (f == 4'd10 || f == 4'd11) ? 32'd1 : b;
        sa = longint'($signed(a));
        sb = longint'($signed(bb));
        s  = int'(b[4:0]);
        case (f)
            4'd0, 4'd10: begin
                u     = {32'b0, a} + {32'b0, bb};
                e.res = u[31:0];
                e.cf  = u[32];
                sr    = sa + sb;
                e.vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1, 4'd11: begin
                e.res = a - bb;
                e.cf  = (a >= bb);
                sr    = sa - sb;
                e.vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = ~(a | b);
            4'd6: e.res = ~a;
            4'd7: begin
                e.res = a << s;
                e.cf  = (s == 0) ? 1'b0 : a[32 - s];
                e.lat = s + 1;
            end
            4'd8: begin
                e.res = a >> s;
                e.cf  = (s == 0) ? 1'b0 : a[s - 1];
                e.lat = s + 1;
            end
            4'd9: begin
                e.res = 32'($signed(a) >>> s);
                e.cf  = (s == 0) ? 1'b0 : a[s - 1];
                e.lat = s + 1;
            end
            4'd12: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd13: e.res = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            4'd14: e.res = a << 16;
            default: begin
                e.res = 32'($countones(a));
                e.lat = 33;
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s func=%0d observed=%0h expected=%0h", tag, cur_func, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   lat;
        int   busy_n;
        e = model(f, a, b);
        cur_func = int'(f);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.func = f; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.func = 4'($urandom);
        lat = 1; busy_n = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(e.lat));
        chk("busy_cycles", 32'(busy_n), 32'(e.lat - 1));
        chk("res", bus.RES, e.res);
        chk("zf", 32'(bus.zf), 32'(e.res == 32'd0));
        chk("nf", 32'(bus.nf), 32'(e.res[31]));
        chk("cf", 32'(bus.cf), 32'(e.cf));
        chk("vf", 32'(bus.vf), 32'(e.vf));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1; bus.A = ~a; bus.B = b + 32'd7; bus.func = 4'd2;
            @(posedge clk);
            @(negedge clk);
            chk("hold_res", bus.RES, e.res);
            chk("hold_flags", {28'd0, bus.zf, bus.nf, bus.cf, bus.vf},
                {28'd0, (e.res == 32'd0), e.res[31], e.cf, e.vf});
            chk("hold_valid", {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    initial begin
        logic spurious;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.func = '0;
        #1 rstn = 1'b0;
        #2;
        chk("rst_res", bus.RES, 32'd0);
        chk("rst_ctl", {28'd0, bus.out_valid, bus.busy, bus.in_ready, 1'b0}, 32'b0010);
        chk("rst_flags", {28'd0, bus.zf, bus.nf, bus.cf, bus.vf}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_op(4'd0,  32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd0,  32'h7FFF_FFFF, 32'd1, 0);
        run_op(4'd1,  32'd3,         32'd5, 0);
        run_op(4'd9,  32'h8000_0000, 32'd31, 0);
        run_op(4'd7,  32'h8000_0001, 32'd1, 0);
        run_op(4'd8,  32'h1234_5678, 32'd0, 0);
        run_op(4'd15, 32'hF0F0_F0F1, 32'd0, 0);
        run_op(4'd4,  32'hDEAD_BEEF, 32'h0F0F_0F0F, 10);
        run_op(4'd12, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd13, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd14, 32'h1234_ABCD, 32'd0, 0);
        run_op(4'd10, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(4'd11, 32'd0,         32'd0, 0);
        run_op(4'd11, 32'h8000_0000, 32'd0, 0);
        run_op(4'd5,  32'h0000_FF00, 32'h00FF_0000, 0);
        run_op(4'd6,  32'h0F0F_0000, 32'd0, 0);
        run_op(4'd8,  32'h8000_0000, 32'd31, 1);

        for (int k = 0; k < 40; k++) begin
            run_op(4'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        // Reset while a long shift is in flight
        run_op(4'd0, 32'd5, 32'd6, 0);
        cur_func = 7;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.A = 32'd1; bus.B = 32'd20; bus.func = 4'd7;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_res", bus.RES, 32'd0);
        chk("midrst_ctl", {30'd0, bus.out_valid, bus.busy}, 32'd0);
        chk("midrst_flags", {28'd0, bus.zf, bus.nf, bus.cf, bus.vf}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) spurious = 1'b1;
        end
        chk("post_rst_quiet", 32'(spurious), 32'd0);
        run_op(4'd3, 32'hA5A5_0000, 32'h0000_5A5A, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
